// File: rtl/traffic_pkg.sv
// Shared types and helpers for the two-road junction controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package traffic_pkg;

  // Nine controller states, ordered as they are walked in normal operation.
  typedef enum logic [3:0] {
    ST_ALLRED_A = 4'd0,
    ST_A_RA     = 4'd1,
    ST_A_G      = 4'd2,
    ST_A_AM     = 4'd3,
    ST_ALLRED_B = 4'd4,
    ST_B_RA     = 4'd5,
    ST_B_G      = 4'd6,
    ST_B_AM     = 4'd7,
    ST_FLASH    = 4'd8
  } state_t;

  // Lamp groups are {red, amber, green}.
  localparam logic [2:0] LAMP_RED       = 3'b100;
  localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
  localparam logic [2:0] LAMP_GREEN     = 3'b001;
  localparam logic [2:0] LAMP_AMBER     = 3'b010;
  localparam logic [2:0] LAMP_OFF       = 3'b000;

  // Dwell times of every phase, bundled so they travel as one value.
  typedef struct packed {
    logic [31:0] all_red;
    logic [31:0] red_amber;
    logic [31:0] green_min;
    logic [31:0] green_b;
    logic [31:0] amber;
    logic [31:0] flash;
  } phase_times_t;

  // Dwell (in cycles) of the phase a state represents. Illegal encodings
  // recover through ALLRED_A, so they map to the all-red dwell.
  function automatic logic [31:0] phase_len(input state_t st, input phase_times_t t);
    logic [31:0] len;
    len = t.all_red;
    case (st)
      ST_ALLRED_A, ST_ALLRED_B: len = t.all_red;
      ST_A_RA, ST_B_RA:         len = t.red_amber;
      ST_A_G:                   len = t.green_min;
      ST_B_G:                   len = t.green_b;
      ST_A_AM, ST_B_AM:         len = t.amber;
      ST_FLASH:                 len = t.flash;
      default:                  len = t.all_red;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
// Latency: load takes effect on the next rising edge; expired is combinational from the count.
// Backpressure: none; counts every cycle it is not loaded.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/traffic_junction_ctrl.sv
// Timed two-road junction controller with latched side-road demand and night-mode flashing amber.
// Latency: inputs sampled on the rising edge; lamps follow the registered state in the next cycle.
// Backpressure: none; b_req is latched until served, flash_en is a level honoured at safe points.
module traffic_junction_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int T_ALL_RED   = 2,
  parameter int T_RED_AMBER = 2,
  parameter int T_GREEN_MIN = 8,
  parameter int T_GREEN_B   = 6,
  parameter int T_AMBER     = 3,
  parameter int T_FLASH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       b_req,
  input  logic       flash_en,
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic       b_pending,
  output logic       b_served,
  output logic [3:0] state_o
);

  localparam phase_times_t TIMES = '{
    all_red:   32'(T_ALL_RED),
    red_amber: 32'(T_RED_AMBER),
    green_min: 32'(T_GREEN_MIN),
    green_b:   32'(T_GREEN_B),
    amber:     32'(T_AMBER),
    flash:     32'(T_FLASH)
  };

  // Timers hold "cycles left minus one", so a T-cycle phase is visible T cycles.
  localparam logic [CNT_W-1:0] ALLRED_RELOAD = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] FLASH_RELOAD  = CNT_W'(T_FLASH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_exp;
  logic             enter_bg;
  logic             enter_flash;
  logic             flash_load;
  logic             flash_exp;
  logic             flash_on;

  // Phase dwell timer; reset value matches the ALLRED_A entry load.
  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_RELOAD)
  ) u_phase_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_exp)
  );

  // Half-period timer for the flashing amber, restarted on FLASH entry and each toggle.
  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (FLASH_RELOAD)
  ) u_flash_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (flash_load),
    .value   (FLASH_RELOAD),
    .expired (flash_exp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ALLRED_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; green only ever leaves through amber, and FLASH is entered from all-red only.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ALLRED_A: if (tmr_exp) state_nxt = flash_en ? ST_FLASH : ST_A_RA;
      ST_A_RA:     if (tmr_exp) state_nxt = ST_A_G;
      ST_A_G:      if (tmr_exp && (b_pending || flash_en)) state_nxt = ST_A_AM;
      ST_A_AM:     if (tmr_exp) state_nxt = ST_ALLRED_B;
      ST_ALLRED_B: if (tmr_exp) state_nxt = flash_en ? ST_FLASH : ST_B_RA;
      ST_B_RA:     if (tmr_exp) state_nxt = ST_B_G;
      ST_B_G:      if (tmr_exp) state_nxt = ST_B_AM;
      ST_B_AM:     if (tmr_exp) state_nxt = ST_ALLRED_A;
      ST_FLASH:    if (!flash_en) state_nxt = ST_ALLRED_A;
      default:     state_nxt = ST_ALLRED_A;
    endcase
  end

  // Reload the phase timer on every state change (illegal states always change to ALLRED_A).
  always_comb begin
    tmr_load    = (state_nxt != state);
    tmr_val     = CNT_W'(phase_len(state_nxt, TIMES) - 32'd1);
    enter_bg    = (state_nxt == ST_B_G) && (state != ST_B_G);
    enter_flash = (state_nxt == ST_FLASH) && (state != ST_FLASH);
    flash_load  = enter_flash || ((state == ST_FLASH) && flash_exp);
  end

  // Flash phase: starts lit on FLASH entry and toggles at each half-period expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_on <= 1'b1;
    end else if (enter_flash) begin
      flash_on <= 1'b1;
    end else if ((state == ST_FLASH) && flash_exp) begin
      flash_on <= ~flash_on;
    end
  end

  // Side-road demand latch; a request on the B_G entry edge beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_pending <= 1'b0;
    end else if (b_req) begin
      b_pending <= 1'b1;
    end else if (enter_bg) begin
      b_pending <= 1'b0;
    end
  end

  // One-cycle served pulse aligned with the first visible cycle of B_G.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_served <= 1'b0;
    end else begin
      b_served <= enter_bg;
    end
  end

  // Lamp decode; a road not named by the state shows red.
  always_comb begin
    light_a = LAMP_RED;
    light_b = LAMP_RED;
    case (state)
      ST_A_RA:  light_a = LAMP_RED_AMBER;
      ST_A_G:   light_a = LAMP_GREEN;
      ST_A_AM:  light_a = LAMP_AMBER;
      ST_B_RA:  light_b = LAMP_RED_AMBER;
      ST_B_G:   light_b = LAMP_GREEN;
      ST_B_AM:  light_b = LAMP_AMBER;
      ST_FLASH: begin
        light_a = flash_on ? LAMP_AMBER : LAMP_OFF;
        light_b = flash_on ? LAMP_AMBER : LAMP_OFF;
      end
      default: begin
        light_a = LAMP_RED;
        light_b = LAMP_RED;
      end
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Directed bench for traffic_junction_ctrl with a cycle-tagged expectation queue.
// Latency: cycle k is the value presented to rising edge k after reset release.
// Backpressure: n/a.
module tb_traffic_junction_ctrl;

  localparam logic [3:0] RED = 4'b0100;
  localparam logic [3:0] RA  = 4'b0110;
  localparam logic [3:0] GRN = 4'b0001;
  localparam logic [3:0] AMB = 4'b0010;
  localparam logic [3:0] OFF = 4'b0000;

  localparam int K_LA    = 0;
  localparam int K_LB    = 1;
  localparam int K_SRV   = 2;
  localparam int K_PEND  = 3;
  localparam int K_STATE = 4;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] val;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       b_req;
  logic       flash_en;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic       b_pending;
  logic       b_served;
  logic [3:0] state_o;

  int   checks;
  int   failures;
  exp_t sb[$];
  int   req_cyc[$];
  int   flash_from;
  int   flash_to;

  traffic_junction_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .b_req     (b_req),
    .flash_en  (flash_en),
    .light_a   (light_a),
    .light_b   (light_b),
    .b_pending (b_pending),
    .b_served  (b_served),
    .state_o   (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int cyc, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [3:0] observe(input int kind);
    logic [3:0] v;
    v = 4'hx;
    case (kind)
      K_LA:    v = {1'b0, light_a};
      K_LB:    v = {1'b0, light_b};
      K_SRV:   v = {3'b000, b_served};
      K_PEND:  v = {3'b000, b_pending};
      default: v = state_o;
    endcase
    return v;
  endfunction

  function automatic string kind_name(input int kind);
    string s;
    case (kind)
      K_LA:    s = "light_a";
      K_LB:    s = "light_b";
      K_SRV:   s = "b_served";
      K_PEND:  s = "b_pending";
      default: s = "state_o";
    endcase
    return s;
  endfunction

  task automatic push(input int kind, input int first, input int last, input logic [3:0] val);
    for (int c = first; c <= last; c++) begin
      exp_t e;
      e.cyc  = c;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
    end
  endtask

  // Pop and compare every expectation tagged with this cycle.
  task automatic score(input int k);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == k) begin
        check(kind_name(sb[i].kind), k, observe(sb[i].kind), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  // Reset the DUT and clear the scenario; returns at the negedge of cycle 0.
  task automatic do_reset();
    rst_n    = 1'b0;
    b_req    = 1'b0;
    flash_en = 1'b0;
    sb.delete();
    req_cyc.delete();
    flash_from = -1;
    flash_to   = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      if (k != 0) @(negedge clk);
      b_req = 1'b0;
      foreach (req_cyc[i]) if (req_cyc[i] == k) b_req = 1'b1;
      flash_en = (k >= flash_from) && (k < flash_to);
      score(k);
    end
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drained observed=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    b_req    = 1'b0;
    flash_en = 1'b0;

    // Idle: no demand, main road green held indefinitely.
    do_reset();
    push(K_STATE, 0, 0, 4'd0);
    push(K_LA, 0, 1, RED);
    push(K_LA, 2, 3, RA);
    push(K_LA, 4, 105, GRN);
    push(K_LB, 0, 105, RED);
    push(K_SRV, 0, 105, 4'd0);
    push(K_PEND, 0, 0, 4'd0);
    push(K_PEND, 105, 105, 4'd0);
    run(106);

    // Side demand pulse at cycle 10: one full B cycle, then back to A green.
    do_reset();
    req_cyc.push_back(10);
    push(K_LA, 4, 11, GRN);
    push(K_LA, 12, 14, AMB);
    push(K_LA, 15, 29, RED);
    push(K_LA, 30, 31, RA);
    push(K_LA, 32, 39, GRN);
    push(K_LB, 0, 16, RED);
    push(K_LB, 17, 18, RA);
    push(K_LB, 19, 24, GRN);
    push(K_LB, 25, 27, AMB);
    push(K_LB, 28, 39, RED);
    push(K_STATE, 19, 19, 4'd6);
    push(K_SRV, 18, 18, 4'd0);
    push(K_SRV, 19, 19, 4'd1);
    push(K_SRV, 20, 24, 4'd0);
    push(K_PEND, 10, 10, 4'd0);
    push(K_PEND, 11, 18, 4'd1);
    push(K_PEND, 19, 39, 4'd0);
    run(40);

    // Early demand: minimum green still honoured.
    do_reset();
    req_cyc.push_back(5);
    push(K_PEND, 5, 5, 4'd0);
    push(K_PEND, 6, 6, 4'd1);
    push(K_LA, 4, 11, GRN);
    push(K_LA, 12, 13, AMB);
    run(14);

    // Night mode: entry through amber and all-red, flashing, exit to ALLRED_A.
    do_reset();
    flash_from = 6;
    flash_to   = 30;
    push(K_LA, 4, 11, GRN);
    push(K_LA, 12, 14, AMB);
    push(K_LA, 15, 16, RED);
    push(K_LA, 17, 20, AMB);
    push(K_LA, 21, 24, OFF);
    push(K_LA, 25, 28, AMB);
    push(K_LA, 29, 30, OFF);
    push(K_LA, 31, 32, RED);
    push(K_LA, 33, 34, RA);
    push(K_LA, 35, 35, GRN);
    push(K_LB, 0, 16, RED);
    push(K_LB, 17, 20, AMB);
    push(K_LB, 21, 24, OFF);
    push(K_LB, 25, 28, AMB);
    push(K_LB, 29, 30, OFF);
    push(K_LB, 31, 35, RED);
    push(K_STATE, 17, 17, 4'd8);
    push(K_STATE, 31, 31, 4'd0);
    push(K_PEND, 20, 20, 4'd0);
    run(36);

    // Requests during B_G are served on the next B cycle after minimum A green.
    do_reset();
    req_cyc.push_back(10);
    req_cyc.push_back(19);
    req_cyc.push_back(22);
    push(K_PEND, 19, 19, 4'd0);
    push(K_PEND, 20, 46, 4'd1);
    push(K_PEND, 47, 52, 4'd0);
    push(K_SRV, 46, 46, 4'd0);
    push(K_SRV, 47, 47, 4'd1);
    push(K_SRV, 48, 48, 4'd0);
    push(K_LA, 32, 39, GRN);
    push(K_LA, 40, 42, AMB);
    push(K_LA, 43, 52, RED);
    push(K_LB, 28, 44, RED);
    push(K_LB, 45, 46, RA);
    push(K_LB, 47, 52, GRN);
    run(53);

    // Reset asserted in the middle of B_G acts without a clock edge.
    do_reset();
    req_cyc.push_back(10);
    req_cyc.push_back(20);
    push(K_LB, 19, 21, GRN);
    push(K_PEND, 21, 21, 4'd1);
    run(22);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_light_a", -1, {1'b0, light_a}, RED);
    check("async_light_b", -1, {1'b0, light_b}, RED);
    check("async_b_pending", -1, {3'b000, b_pending}, 4'd0);
    check("async_b_served", -1, {3'b000, b_served}, 4'd0);
    check("async_state_o", -1, state_o, 4'd0);

    // Sequence restarts from ALLRED_A after release.
    do_reset();
    push(K_STATE, 0, 0, 4'd0);
    push(K_LA, 0, 1, RED);
    push(K_LA, 2, 3, RA);
    push(K_LA, 4, 5, GRN);
    push(K_LB, 0, 5, RED);
    push(K_PEND, 0, 5, 4'd0);
    run(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
